// File: rtl/pipe_front_regs_pkg.sv
// Shared constants for the front-end pipeline registers: reset PC, control bundle layout
// and the instruction used when a stage is flushed.
package pipe_front_regs_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int          CNT_W_DEFAULT    = 16;

    // Control bundle: {RegWrite,MemtoReg,MemWrite,ALUSrc,RegDst,ALUControl[2:0]}
    localparam int CTRL_W        = 8;
    localparam int CTRL_REGWRITE = 7;
    localparam int CTRL_MEMTOREG = 6;
    localparam int CTRL_MEMWRITE = 5;
    localparam int CTRL_ALUSRC   = 4;
    localparam int CTRL_REGDST   = 3;
    localparam int CTRL_ALUCTL_HI = 2;
    localparam int CTRL_ALUCTL_LO = 0;

    // sll $0,$0,0 encodes as all zeros, so a cleared register is a nop.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/pipe_front_regs_flopenrc.sv
// Register with synchronous reset, enable and synchronous clear.
// Priority: reset, then enable; clear only takes effect while enabled.
module flopenrc #(
    parameter int               WIDTH   = 32,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] q_q;

    always_comb begin
        q_d = q_q;
        if (en) begin
            q_d = clr ? '0 : d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q <= RST_VAL;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/pipe_front_regs.sv
// PC, IF/ID and ID/EX pipeline registers driven by the hazard unit, plus saturating
// counters of stall cycles, bubbles and applied IF/ID redirects.
module pipe_front_regs
    import pipe_front_regs_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          CNT_W    = CNT_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              StallF,
    input  logic              StallD,
    input  logic              FlushE,
    input  logic              PCSrcD,
    input  logic              Jump,
    input  logic [31:0]       PCNextF,
    input  logic [31:0]       InstrF,
    input  logic [31:0]       PCPlus4F,
    input  logic [7:0]        CtrlD,
    input  logic [31:0]       RD1D,
    input  logic [31:0]       RD2D,
    input  logic [31:0]       SignImmD,
    input  logic [4:0]        RsD,
    input  logic [4:0]        RtD,
    input  logic [4:0]        RdD,
    output logic [31:0]       PCF,
    output logic [31:0]       InstrD,
    output logic [31:0]       PCPlus4D,
    output logic [7:0]        CtrlE,
    output logic [31:0]       RD1E,
    output logic [31:0]       RD2E,
    output logic [31:0]       SignImmE,
    output logic [4:0]        RsE,
    output logic [4:0]        RtE,
    output logic [4:0]        RdE,
    output logic [CNT_W-1:0]  StallCnt,
    output logic [CNT_W-1:0]  BubbleCnt,
    output logic [CNT_W-1:0]  RedirCnt
);

    localparam int IFID_W = 64;
    localparam int IDEX_W = CTRL_W + 96 + 15;

    logic              flush_d;
    logic              redir_applied;
    logic [IFID_W-1:0] ifid_q;
    logic [IDEX_W-1:0] idex_q;

    assign flush_d       = PCSrcD | Jump;
    assign redir_applied = flush_d & ~StallD;

    flopenrc #(.WIDTH(32), .RST_VAL(RESET_PC)) u_pc (
        .clk   (clk),
        .reset (reset),
        .en    (~StallF),
        .clr   (1'b0),
        .d     (PCNextF),
        .q     (PCF)
    );

    // A stalled decode stage keeps its instruction even when a redirect is pending;
    // decode re-presents the redirect once the stall clears.
    flopenrc #(.WIDTH(IFID_W)) u_ifid (
        .clk   (clk),
        .reset (reset),
        .en    (~StallD),
        .clr   (flush_d),
        .d     ({InstrF, PCPlus4F}),
        .q     (ifid_q)
    );

    assign {InstrD, PCPlus4D} = ifid_q;

    flopenrc #(.WIDTH(IDEX_W)) u_idex (
        .clk   (clk),
        .reset (reset),
        .en    (1'b1),
        .clr   (FlushE),
        .d     ({CtrlD, RD1D, RD2D, SignImmD, RsD, RtD, RdD}),
        .q     (idex_q)
    );

    assign {CtrlE, RD1E, RD2E, SignImmE, RsE, RtE, RdE} = idex_q;

    logic [CNT_W-1:0] stall_cnt_d,  stall_cnt_q;
    logic [CNT_W-1:0] bubble_cnt_d, bubble_cnt_q;
    logic [CNT_W-1:0] redir_cnt_d,  redir_cnt_q;

    // Counters stick at all-ones rather than wrapping.
    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        redir_cnt_d  = redir_cnt_q;
        if (StallF && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (FlushE && (bubble_cnt_q != '1)) begin
            bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
        end
        if (redir_applied && (redir_cnt_q != '1)) begin
            redir_cnt_d = redir_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
            redir_cnt_q  <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
            redir_cnt_q  <= redir_cnt_d;
        end
    end

    assign StallCnt  = stall_cnt_q;
    assign BubbleCnt = bubble_cnt_q;
    assign RedirCnt  = redir_cnt_q;

endmodule

// File: tb/tb_pipe_front_regs.sv
// Scoreboard bench for pipe_front_regs: each stimulus vector pushes the expected
// post-edge register state, and a monitor pops and compares after every rising edge.
module tb_pipe_front_regs;
    import pipe_front_regs_pkg::*;

    localparam logic [31:0] TB_RESET_PC = 32'hBFC0_0000;
    localparam int          TB_CNT_W    = 4;

    logic        clk = 1'b0;
    logic        reset, StallF, StallD, FlushE, PCSrcD, Jump;
    logic [31:0] PCNextF, InstrF, PCPlus4F, RD1D, RD2D, SignImmD;
    logic [7:0]  CtrlD;
    logic [4:0]  RsD, RtD, RdD;
    logic [31:0] PCF, InstrD, PCPlus4D, RD1E, RD2E, SignImmE;
    logic [7:0]  CtrlE;
    logic [4:0]  RsE, RtE, RdE;
    logic [TB_CNT_W-1:0] StallCnt, BubbleCnt, RedirCnt;

    always #5 clk = ~clk;

    pipe_front_regs #(.RESET_PC(TB_RESET_PC), .CNT_W(TB_CNT_W)) dut (
        .clk(clk), .reset(reset), .StallF(StallF), .StallD(StallD), .FlushE(FlushE),
        .PCSrcD(PCSrcD), .Jump(Jump), .PCNextF(PCNextF), .InstrF(InstrF), .PCPlus4F(PCPlus4F),
        .CtrlD(CtrlD), .RD1D(RD1D), .RD2D(RD2D), .SignImmD(SignImmD),
        .RsD(RsD), .RtD(RtD), .RdD(RdD),
        .PCF(PCF), .InstrD(InstrD), .PCPlus4D(PCPlus4D), .CtrlE(CtrlE),
        .RD1E(RD1E), .RD2E(RD2E), .SignImmE(SignImmE),
        .RsE(RsE), .RtE(RtE), .RdE(RdE),
        .StallCnt(StallCnt), .BubbleCnt(BubbleCnt), .RedirCnt(RedirCnt)
    );

    typedef struct {
        logic [31:0] pcf, instrD, pcPlus4D, rd1E, rd2E, immE;
        logic [7:0]  ctrlE;
        logic [4:0]  rsE, rtE, rdE;
        logic [3:0]  stallCnt, bubbleCnt, redirCnt;
    } expT;

    expT model;
    expT expQ[$];
    int  vecCount    = 0;
    int  nCompares   = 0;
    int  nMiscompare = 0;

    function automatic logic [3:0] satInc(input logic [3:0] c, input logic hit);
        if (!hit || c == 4'hF) return c;
        return c + 4'd1;
    endfunction

    task automatic checkOutput(input string name, input int vec, input logic [31:0] actual,
                               input logic [31:0] expected);
        nCompares++;
        if (actual !== expected) begin
            nMiscompare++;
            $display("[TB] FAIL vec%0d %s: got %h, expected %h", vec, name, actual, expected);
        end
    endtask

    // D-stage data is derived from the vector number so each ID/EX load is distinct.
    task automatic applyStimulus(input logic rst, input logic sF, input logic sD, input logic fE,
                                 input logic br, input logic jmp,
                                 input logic [31:0] pcNext, input logic [31:0] instr);
        logic [31:0] pc4;
        logic [7:0]  ctl;
        logic [31:0] r1, r2, imm;
        logic [4:0]  rs, rt, rd;
        @(negedge clk);
        pc4 = 32'h4000_0000 | 32'(vecCount);
        ctl = 8'(vecCount * 37 + 1);
        r1  = 32'h1100_0000 + 32'(vecCount);
        r2  = 32'h2200_0000 + 32'(vecCount);
        imm = 32'hFFFF_0000 | 32'(vecCount);
        rs  = 5'(vecCount + 1);
        rt  = 5'(vecCount + 2);
        rd  = 5'(vecCount + 3);
        reset = rst; StallF = sF; StallD = sD; FlushE = fE; PCSrcD = br; Jump = jmp;
        PCNextF = pcNext; InstrF = instr; PCPlus4F = pc4;
        CtrlD = ctl; RD1D = r1; RD2D = r2; SignImmD = imm; RsD = rs; RtD = rt; RdD = rd;
        if (rst) begin
            model = '{pcf: TB_RESET_PC, instrD: 0, pcPlus4D: 0, rd1E: 0, rd2E: 0, immE: 0,
                      ctrlE: 0, rsE: 0, rtE: 0, rdE: 0, stallCnt: 0, bubbleCnt: 0, redirCnt: 0};
        end else begin
            model.stallCnt  = satInc(model.stallCnt, sF);
            model.bubbleCnt = satInc(model.bubbleCnt, fE);
            model.redirCnt  = satInc(model.redirCnt, (br | jmp) & ~sD);
            if (!sF) model.pcf = pcNext;
            if (!sD) begin
                model.instrD   = (br | jmp) ? NOP_INSTR : instr;
                model.pcPlus4D = (br | jmp) ? 32'h0 : pc4;
            end
            if (fE) begin
                model.ctrlE = 0; model.rd1E = 0; model.rd2E = 0; model.immE = 0;
                model.rsE = 0; model.rtE = 0; model.rdE = 0;
            end else begin
                model.ctrlE = ctl; model.rd1E = r1; model.rd2E = r2; model.immE = imm;
                model.rsE = rs; model.rtE = rt; model.rdE = rd;
            end
        end
        expQ.push_back(model);
        vecCount++;
    endtask

    // Monitor: every register updates each cycle, so every post-edge sample is an output.
    always @(posedge clk) begin
        expT e;
        #2;
        if (expQ.size() != 0) begin
            e = expQ.pop_front();
            checkOutput("PCF",       vecCount, PCF,             e.pcf);
            checkOutput("InstrD",    vecCount, InstrD,          e.instrD);
            checkOutput("PCPlus4D",  vecCount, PCPlus4D,        e.pcPlus4D);
            checkOutput("CtrlE",     vecCount, 32'(CtrlE),      32'(e.ctrlE));
            checkOutput("RD1E",      vecCount, RD1E,            e.rd1E);
            checkOutput("RD2E",      vecCount, RD2E,            e.rd2E);
            checkOutput("SignImmE",  vecCount, SignImmE,        e.immE);
            checkOutput("RsE",       vecCount, 32'(RsE),        32'(e.rsE));
            checkOutput("RtE",       vecCount, 32'(RtE),        32'(e.rtE));
            checkOutput("RdE",       vecCount, 32'(RdE),        32'(e.rdE));
            checkOutput("StallCnt",  vecCount, 32'(StallCnt),   32'(e.stallCnt));
            checkOutput("BubbleCnt", vecCount, 32'(BubbleCnt),  32'(e.bubbleCnt));
            checkOutput("RedirCnt",  vecCount, 32'(RedirCnt),   32'(e.redirCnt));
        end
    end

    task automatic afterEdge();
        @(posedge clk);
        #3;
    endtask

    initial begin
        int waitCycles;
        reset = 1'b1; StallF = 1'b1; StallD = 1'b0; FlushE = 1'b0; PCSrcD = 1'b0; Jump = 1'b0;
        PCNextF = '0; InstrF = '0; PCPlus4F = '0; CtrlD = '0; RD1D = '0; RD2D = '0;
        SignImmD = '0; RsD = '0; RtD = '0; RdD = '0;
        model = '{default: 0};

        // Reset for two cycles with the PC stall asserted
        applyStimulus(1, 1, 0, 0, 0, 0, 32'h0000_0040, 32'h0000_00AA);
        applyStimulus(1, 1, 0, 0, 0, 0, 32'h0000_0044, 32'h0000_00BB);
        afterEdge();
        checkOutput("ResetPC", vecCount, PCF, 32'hBFC0_0000);

        // Free run
        applyStimulus(0, 0, 0, 0, 0, 0, 32'h0000_0004, 32'h0000_000A);
        applyStimulus(0, 0, 0, 0, 0, 0, 32'h0000_0008, 32'h0000_000B);
        applyStimulus(0, 0, 0, 0, 0, 0, 32'h0000_000C, 32'h0000_000C);
        afterEdge();
        checkOutput("FreeRunInstrD", vecCount, InstrD, 32'h0000_000C);

        // lw-use: load the lw into decode, then stall F/D and bubble E together
        applyStimulus(0, 0, 0, 0, 0, 0, 32'h0000_0010, 32'h8C0A_0004);
        applyStimulus(0, 1, 1, 1, 0, 0, 32'h0000_0014, 32'h0000_1111);
        afterEdge();
        checkOutput("LwUseInstrD",   vecCount, InstrD, 32'h8C0A_0004);
        checkOutput("LwUseRegWrite", vecCount, 32'(CtrlE[CTRL_REGWRITE]), 32'h0);
        applyStimulus(0, 0, 0, 0, 0, 0, 32'h0000_0014, 32'h0000_2222);

        // Branch taken and jump both flush IF/ID
        applyStimulus(0, 0, 0, 0, 1, 0, 32'h0000_0100, 32'h1234_5678);
        afterEdge();
        checkOutput("BranchFlushInstrD", vecCount, InstrD, 32'h0000_0000);
        applyStimulus(0, 0, 0, 0, 0, 0, 32'h0000_0104, 32'h0000_3333);
        applyStimulus(0, 0, 0, 0, 0, 1, 32'h0000_0200, 32'h0000_4444);

        // Stall beats flush, then the re-presented redirect is applied
        applyStimulus(0, 0, 0, 0, 0, 0, 32'h0000_0204, 32'h0000_5555);
        applyStimulus(0, 1, 1, 0, 1, 0, 32'h0000_0300, 32'h0000_6666);
        afterEdge();
        checkOutput("StallBeatsFlushInstrD", vecCount, InstrD, 32'h0000_5555);
        applyStimulus(0, 0, 0, 0, 1, 0, 32'h0000_0300, 32'h0000_6666);

        // Saturation: 20 stall cycles on a 4-bit counter
        for (int i = 0; i < 20; i++) begin
            applyStimulus(0, 1, 1, (i % 3) == 0, 0, 0, 32'h0000_0400, 32'h0000_7777);
        end
        afterEdge();
        checkOutput("StallCntSat", vecCount, 32'(StallCnt), 32'h0000_000F);

        // Reset mid-stall/mid-flush clears everything in one edge
        applyStimulus(1, 1, 1, 1, 1, 1, 32'h0000_0500, 32'h0000_8888);
        afterEdge();
        checkOutput("MidStallResetCnt", vecCount, 32'(StallCnt), 32'h0);
        applyStimulus(0, 0, 0, 0, 0, 0, 32'h0000_0600, 32'h0000_9999);

        waitCycles = 0;
        while (expQ.size() != 0 && waitCycles < 10) begin
            @(posedge clk);
            waitCycles++;
        end
        #5;
        if (expQ.size() != 0) begin
            nMiscompare++;
            $display("[TB] FAIL drain: %0d entries left, expected 0", expQ.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, nMiscompare);
        $finish;
    end

endmodule
